stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Mode and run/stop controller for the stopwatch/clock design. It sits between the button debouncers and the stopwatch/clock counters. It generates the shared 1 kHz sample tick that all debouncers use, and it turns debounced single-cycle button pulses into run/stop/clear control and clock-set increment pulses. It also produces the gated 100 Hz centisecond tick that drives the stopwatch counter.

## Interface

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1000, debouncer sample tick rate; prescaler terminal count = CLK_HZ/TICK_HZ - 1.
- CS_DIV, 10, sample ticks per centisecond tick.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0).
- i_btn_run  in  1  debounced pulse, one cycle.
- i_btn_clear  in  1  debounced pulse, one cycle.
- i_btn_mode  in  1  debounced pulse, one cycle.
- o_tick_1khz  out  1  one-cycle sample tick to all debouncers; free-running.
- o_tick_100hz  out  1  one-cycle centisecond tick; only while running.
- o_run  out  1  stopwatch running level.
- o_clear  out  1  one-cycle stopwatch clear pulse.
- o_mode  out  1  0 = stopwatch view, 1 = clock view.
- o_hour_inc  out  1  one-cycle clock hour increment.
- o_min_inc  out  1  one-cycle clock minute increment.

## Operation

- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and wraps. It runs in every state and mode. o_tick_1khz is registered high for the one cycle after the terminal count.
- Centisecond divider cs_cnt: range 0..CS_DIV-1.
  - Advances only on o_tick_1khz while state = RUN.
  - At CS_DIV-1 it wraps to 0 and pulses o_tick_100hz.
  - Holds its value in STOP, so the phase is preserved across stop/resume.
  - Forced to 0 in CLEAR.
- Stopwatch FSM has three states: STOP (reset state), RUN, CLEAR.
  - STOP + run pulse -> RUN.
  - RUN + run pulse -> STOP.
  - STOP + clear pulse -> CLEAR.
  - CLEAR -> STOP unconditionally after 1 cycle.
  - RUN + clear pulse -> ignored.
- o_run = (state == RUN), registered. o_clear = (state == CLEAR).
- Mode: i_btn_mode toggles o_mode.
- With o_mode = 1, button roles change:
  - i_btn_run produces o_hour_inc and i_btn_clear produces o_min_inc.
  - These pulses do not reach the FSM; the stopwatch keeps running or holding in the background.
- Same-cycle priority: mode > run > clear. Lower-priority pulses in that cycle are dropped, not queued.
- Inputs are assumed to be single-cycle pulses. A level held high is treated as a pulse every cycle, so the block does not protect against it.

## Timing

- Reset (rst = 0) takes effect immediately, asynchronously, including mid-operation:
  - All outputs 0, state STOP, o_mode 0.
  - Prescaler and cs_cnt at 0.
- After release, the first o_tick_1khz is asserted in cycle CLK_HZ/TICK_HZ (100_000 at the defaults). Pulses then repeat every CLK_HZ/TICK_HZ cycles.
- Button response: an input pulse in cycle N changes o_run / o_mode, or asserts o_clear / o_hour_inc / o_min_inc, in cycle N+1.
- o_clear and the increment pulses are exactly 1 cycle wide.
- A run pulse in the same cycle as CLEAR is ignored.
- o_tick_100hz is asserted in the cycle after the o_tick_1khz that wraps cs_cnt, only if state is RUN in the wrapping cycle. Period = CS_DIV × prescaler period.
- Stop in the same cycle as a wrapping o_tick_1khz: the tick is lost and cs_cnt holds at CS_DIV-1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

Use CLK_HZ = 1000, TICK_HZ = 100, CS_DIV = 10 (prescaler period 10 cycles, centisecond period 100 cycles).

1. Release reset, no buttons -> o_tick_1khz high at cycles 10, 20, 30…; o_tick_100hz, o_run, o_mode and all pulses stay 0.
2. Run pulse at cycle 5 -> o_run = 1 at cycle 6. o_tick_100hz every 100 cycles. A second run pulse after 35 sample ticks -> o_run = 0 and ticks stop. Resume -> the first o_tick_100hz comes after 5 more sample ticks (phase held).
3. Clear pulse during RUN -> ignored, o_run stays 1. In STOP, clear pulse -> o_clear high for exactly 1 cycle and cs_cnt = 0. The next run then needs 10 full sample ticks for the first centisecond tick.
4. Mode pulse -> o_mode = 1. Run pulse -> o_hour_inc for 1 cycle with o_run unchanged. Clear pulse -> o_min_inc for 1 cycle. Second mode pulse -> o_mode = 0.
5. Mode and run in the same cycle in STOP -> o_mode toggles and o_run stays 0. Run and clear in the same cycle in STOP -> RUN, with no o_clear.
6. rst = 0 mid-RUN, off a clock edge -> all outputs 0 immediately. After release, o_tick_1khz restarts at cycle 10.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sample-tick prescaler, centisecond divider and run/stop/clear/mode control
// Turns debounced button pulses into stopwatch control and clock-set increments.
module stopwatch_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int CS_DIV  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_run,
   input  logic i_btn_clear,
   input  logic i_btn_mode,
   output logic o_tick_1khz,
   output logic o_tick_100hz,
   output logic o_run,
   output logic o_clear,
   output logic o_mode,
   output logic o_hour_inc,
   output logic o_min_inc
);
   localparam int PRE_N = CLK_HZ / TICK_HZ;
   localparam int PW    = (PRE_N > 1) ? $clog2(PRE_N) : 1;
   localparam int CW    = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [CW-1:0] cs_q, cs_d;
   logic          tick_q, tick_d;
   logic          cs_tick_q, cs_tick_d;
   logic          mode_q, mode_d;
   logic          hour_q, hour_d;
   logic          min_q, min_d;
   logic          pre_end, cs_end, run_evt, clr_evt, adv;

   always_comb begin
      pre_end   = pre_q == PW'(PRE_N - 1);
      pre_d     = pre_end ? '0 : pre_q + 1'b1;
      tick_d    = pre_end;
      // mode beats run beats clear; losers in the same cycle are dropped
      run_evt   = i_btn_run && !i_btn_mode;
      clr_evt   = i_btn_clear && !i_btn_run && !i_btn_mode;
      mode_d    = mode_q ^ i_btn_mode;
      hour_d    = mode_q && run_evt;
      min_d     = mode_q && clr_evt;
      state_d   = state_q;
      if (state_q == ST_CLEAR)
         state_d = ST_STOP;
      else if (!mode_q && run_evt)
         state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
      else if (!mode_q && clr_evt && state_q == ST_STOP)
         state_d = ST_CLEAR;
      // a stop landing on a wrapping sample tick loses that tick
      adv       = tick_q && state_q == ST_RUN && state_d == ST_RUN;
      cs_end    = cs_q == CW'(CS_DIV - 1);
      cs_d      = (state_q == ST_CLEAR) ? '0 : adv ? (cs_end ? '0 : cs_q + 1'b1) : cs_q;
      cs_tick_d = adv && cs_end;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_STOP;
         pre_q     <= '0;
         cs_q      <= '0;
         tick_q    <= 1'b0;
         cs_tick_q <= 1'b0;
         mode_q    <= 1'b0;
         hour_q    <= 1'b0;
         min_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cs_q      <= cs_d;
         tick_q    <= tick_d;
         cs_tick_q <= cs_tick_d;
         mode_q    <= mode_d;
         hour_q    <= hour_d;
         min_q     <= min_d;
      end
   end

   assign o_tick_1khz  = tick_q;
   assign o_tick_100hz = cs_tick_q;
   assign o_run        = state_q == ST_RUN;
   assign o_clear      = state_q == ST_CLEAR;
   assign o_mode       = mode_q;
   assign o_hour_inc   = hour_q;
   assign o_min_inc    = min_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl with a 10-cycle prescaler and CS_DIV = 10
// cyc counts clock edges since reset release, so cycle N is the window after edge N.
module tb_stopwatch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_btn_run = 1'b0, i_btn_clear = 1'b0, i_btn_mode = 1'b0;
   logic o_tick_1khz, o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc;
   int   cyc, total, passed;

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .CS_DIV(10)) dut (
      .clk(clk), .rst(rst),
      .i_btn_run(i_btn_run), .i_btn_clear(i_btn_clear), .i_btn_mode(i_btn_mode),
      .o_tick_1khz(o_tick_1khz), .o_tick_100hz(o_tick_100hz), .o_run(o_run),
      .o_clear(o_clear), .o_mode(o_mode), .o_hour_inc(o_hour_inc), .o_min_inc(o_min_inc)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else cyc <= cyc + 1;

   task automatic goto(input int c);
      int guard = 0;
      while (cyc < c && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc != c) begin
         total++;
         $display("FAIL goto: cycle=%0d target=%0d", cyc, c);
      end
   endtask

   task automatic restart();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      total++; if ({o_tick_1khz, o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc} !== 7'b0)
         $display("FAIL reset_outs: got=%b exp=0000000", {o_tick_1khz, o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc}); else passed++;
      @(posedge clk);
      #1 rst = 1'b1;
      goto(9);
      total++; if (o_tick_1khz !== 1'b0) $display("FAIL tick_c9: got=%b exp=0", o_tick_1khz); else passed++;
      goto(10);
      total++; if (o_tick_1khz !== 1'b1) $display("FAIL tick_c10: got=%b exp=1", o_tick_1khz); else passed++;
      goto(11);
      total++; if (o_tick_1khz !== 1'b0) $display("FAIL tick_c11: got=%b exp=0", o_tick_1khz); else passed++;
      goto(20);
      total++; if (o_tick_1khz !== 1'b1) $display("FAIL tick_c20: got=%b exp=1", o_tick_1khz); else passed++;
      goto(30);
      total++; if ({o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc} !== 6'b0)
         $display("FAIL idle_outs: got=%b exp=000000", {o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc}); else passed++;
   endtask

   task automatic test_run();
      int n = 0;
      restart();
      goto(5); i_btn_run = 1'b1;
      goto(6); i_btn_run = 1'b0;
      total++; if (o_run !== 1'b1) $display("FAIL run_on: got=%b exp=1", o_run); else passed++;
      goto(100);
      total++; if (o_tick_100hz !== 1'b0) $display("FAIL cs_c100: got=%b exp=0", o_tick_100hz); else passed++;
      goto(101);
      total++; if (o_tick_100hz !== 1'b1) $display("FAIL cs_c101: got=%b exp=1", o_tick_100hz); else passed++;
      goto(102);
      total++; if (o_tick_100hz !== 1'b0) $display("FAIL cs_c102: got=%b exp=0", o_tick_100hz); else passed++;
      goto(201);
      total++; if (o_tick_100hz !== 1'b1) $display("FAIL cs_c201: got=%b exp=1", o_tick_100hz); else passed++;
      goto(355); i_btn_run = 1'b1;
      goto(356); i_btn_run = 1'b0;
      total++; if (o_run !== 1'b0) $display("FAIL run_off: got=%b exp=0", o_run); else passed++;
      for (int c = 357; c <= 460; c++) begin
         goto(c);
         n += int'(o_tick_100hz);
      end
      total++; if (n != 0) $display("FAIL cs_stopped: ticks=%0d exp=0", n); else passed++;
      goto(465); i_btn_run = 1'b1;
      goto(466); i_btn_run = 1'b0;
      goto(510);
      total++; if (o_tick_100hz !== 1'b0) $display("FAIL resume_early: got=%b exp=0", o_tick_100hz); else passed++;
      goto(511);
      total++; if (o_tick_100hz !== 1'b1) $display("FAIL resume_phase: got=%b exp=1", o_tick_100hz); else passed++;
   endtask

   task automatic test_clear();
      goto(515); i_btn_clear = 1'b1;
      goto(516); i_btn_clear = 1'b0;
      total++; if ({o_run, o_clear} !== 2'b10) $display("FAIL clear_in_run: run,clear=%b exp=10", {o_run, o_clear}); else passed++;
      goto(525); i_btn_run = 1'b1;
      goto(526); i_btn_run = 1'b0;
      total++; if (o_run !== 1'b0) $display("FAIL stop_before_clear: got=%b exp=0", o_run); else passed++;
      goto(530); i_btn_clear = 1'b1;
      goto(531); i_btn_clear = 1'b0;
      total++; if (o_clear !== 1'b1) $display("FAIL clear_pulse: got=%b exp=1", o_clear); else passed++;
      goto(532);
      total++; if ({o_clear, o_run} !== 2'b00) $display("FAIL clear_width: clear,run=%b exp=00", {o_clear, o_run}); else passed++;
      goto(535); i_btn_run = 1'b1;
      goto(536); i_btn_run = 1'b0;
      goto(621);
      total++; if (o_tick_100hz !== 1'b0) $display("FAIL cleared_phase: got=%b exp=0", o_tick_100hz); else passed++;
      goto(631);
      total++; if (o_tick_100hz !== 1'b1) $display("FAIL cleared_first: got=%b exp=1", o_tick_100hz); else passed++;
      goto(635); i_btn_run = 1'b1;
      goto(636); i_btn_run = 1'b0;
   endtask

   task automatic test_mode();
      goto(640); i_btn_mode = 1'b1;
      goto(641); i_btn_mode = 1'b0;
      total++; if (o_mode !== 1'b1) $display("FAIL mode_on: got=%b exp=1", o_mode); else passed++;
      goto(645); i_btn_run = 1'b1;
      goto(646); i_btn_run = 1'b0;
      total++; if ({o_hour_inc, o_run} !== 2'b10) $display("FAIL hour_inc: hour,run=%b exp=10", {o_hour_inc, o_run}); else passed++;
      goto(647);
      total++; if (o_hour_inc !== 1'b0) $display("FAIL hour_width: got=%b exp=0", o_hour_inc); else passed++;
      goto(650); i_btn_clear = 1'b1;
      goto(651); i_btn_clear = 1'b0;
      total++; if ({o_min_inc, o_clear} !== 2'b10) $display("FAIL min_inc: min,clear=%b exp=10", {o_min_inc, o_clear}); else passed++;
      goto(652);
      total++; if (o_min_inc !== 1'b0) $display("FAIL min_width: got=%b exp=0", o_min_inc); else passed++;
      goto(655); i_btn_mode = 1'b1;
      goto(656); i_btn_mode = 1'b0;
      total++; if (o_mode !== 1'b0) $display("FAIL mode_off: got=%b exp=0", o_mode); else passed++;
   endtask

   task automatic test_priority();
      goto(660); i_btn_mode = 1'b1; i_btn_run = 1'b1;
      goto(661); i_btn_mode = 1'b0; i_btn_run = 1'b0;
      total++; if ({o_mode, o_run, o_hour_inc} !== 3'b100) $display("FAIL mode_over_run: mode,run,hour=%b exp=100", {o_mode, o_run, o_hour_inc}); else passed++;
      goto(665); i_btn_mode = 1'b1;
      goto(666); i_btn_mode = 1'b0;
      goto(670); i_btn_run = 1'b1; i_btn_clear = 1'b1;
      goto(671); i_btn_run = 1'b0; i_btn_clear = 1'b0;
      total++; if ({o_run, o_clear, o_mode} !== 3'b100) $display("FAIL run_over_clear: run,clear,mode=%b exp=100", {o_run, o_clear, o_mode}); else passed++;
      goto(770);
      total++; if (o_tick_1khz !== 1'b1) $display("FAIL wrap_tick: got=%b exp=1", o_tick_1khz); else passed++;
      i_btn_run = 1'b1;
      goto(771); i_btn_run = 1'b0;
      total++; if ({o_run, o_tick_100hz} !== 2'b00) $display("FAIL stop_on_wrap: run,cs=%b exp=00", {o_run, o_tick_100hz}); else passed++;
      goto(775); i_btn_run = 1'b1;
      goto(776); i_btn_run = 1'b0;
      goto(781);
      total++; if (o_tick_100hz !== 1'b1) $display("FAIL held_at_end: got=%b exp=1", o_tick_100hz); else passed++;
   endtask

   task automatic test_async_reset();
      goto(782); i_btn_mode = 1'b1;
      goto(783); i_btn_mode = 1'b0;
      total++; if ({o_run, o_mode} !== 2'b11) $display("FAIL pre_reset: run,mode=%b exp=11", {o_run, o_mode}); else passed++;
      goto(785);
      #2 rst = 1'b0;
      #1;
      total++; if ({o_tick_1khz, o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc} !== 7'b0)
         $display("FAIL async_reset: got=%b exp=0000000", {o_tick_1khz, o_tick_100hz, o_run, o_clear, o_mode, o_hour_inc, o_min_inc}); else passed++;
      @(posedge clk);
      #1 rst = 1'b1;
      goto(9);
      total++; if (o_tick_1khz !== 1'b0) $display("FAIL rst_tick_c9: got=%b exp=0", o_tick_1khz); else passed++;
      goto(10);
      total++; if ({o_tick_1khz, o_run, o_mode} !== 3'b100) $display("FAIL rst_tick_c10: tick,run,mode=%b exp=100", {o_tick_1khz, o_run, o_mode}); else passed++;
   endtask

   initial begin
      total = 0;
      passed = 0;
      test_reset();
      test_run();
      test_clear();
      test_mode();
      test_priority();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
